// File: rtl/scan_timing_pkg.sv
// ---------------------------------------------------------------------------
// scan_timing_pkg
// Shared definitions for the scan trigger generator: FSM state encoding,
// default counter width and the largest supported channel count.
// No ports (package).
// ---------------------------------------------------------------------------
package scan_timing_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int MAX_CH    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/scan_trigger_gen_if.sv
// ---------------------------------------------------------------------------
// scan_trigger_gen_if
// Groups the control, configuration and status signals of the scan trigger
// generator.
//   master : drives start/abort and all cfg_* fields, observes status
//   slave  : the generator itself (busy, trig_out, line_start, point_idx,
//            line_idx, done, cfg_err are outputs)
// ---------------------------------------------------------------------------
interface scan_trigger_gen_if
  import scan_timing_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic                    start;
  logic                    abort;
  logic [CNT_W-1:0]        cfg_points;
  logic [CNT_W-1:0]        cfg_lines;
  logic [CNT_W-1:0]        cfg_cpp;
  logic [NUM_CH*CNT_W-1:0] cfg_ch_delay;
  logic [NUM_CH*CNT_W-1:0] cfg_ch_width;
  logic [NUM_CH-1:0]       cfg_ch_en;
  logic [NUM_CH-1:0]       cfg_ch_pol;
  logic                    cfg_repeat;

  logic                    busy;
  logic [NUM_CH-1:0]       trig_out;
  logic                    line_start;
  logic [CNT_W-1:0]        point_idx;
  logic [CNT_W-1:0]        line_idx;
  logic                    done;
  logic                    cfg_err;

  modport master (
    output start, abort, cfg_points, cfg_lines, cfg_cpp, cfg_ch_delay,
           cfg_ch_width, cfg_ch_en, cfg_ch_pol, cfg_repeat,
    input  busy, trig_out, line_start, point_idx, line_idx, done, cfg_err
  );

  modport slave (
    input  start, abort, cfg_points, cfg_lines, cfg_cpp, cfg_ch_delay,
           cfg_ch_width, cfg_ch_en, cfg_ch_pol, cfg_repeat,
    output busy, trig_out, line_start, point_idx, line_idx, done, cfg_err
  );

endinterface

// File: rtl/scan_trig_ch.sv
// ---------------------------------------------------------------------------
// scan_trig_ch
// One trigger channel: holds its delay/width/enable/polarity captured at the
// accepted start and produces a registered pulse inside each point.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   load               : capture the channel configuration this cycle
//   run                : generator is stepping through a point this cycle
//   delay_in, width_in,
//   en_in, pol_in      : live channel configuration
//   cyc, cpp           : current cycle within the point, latched cycles/point
//   trig               : registered channel output
// ---------------------------------------------------------------------------
module scan_trig_ch
  import scan_timing_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] delay_in,
  input  logic [CNT_W-1:0] width_in,
  input  logic             en_in,
  input  logic             pol_in,
  input  logic [CNT_W-1:0] cyc,
  input  logic [CNT_W-1:0] cpp,
  output logic             trig
);

  logic [CNT_W-1:0] delay_q;
  logic [CNT_W-1:0] width_q;
  logic             en_q;
  logic             pol_q;
  logic [CNT_W:0]   win_end;
  logic             active;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      delay_q <= '0;
      width_q <= '0;
      en_q    <= 1'b0;
      pol_q   <= 1'b0;
    end else if (load) begin
      delay_q <= delay_in;
      width_q <= width_in;
      en_q    <= en_in;
      pol_q   <= pol_in;
    end
  end

  // Window end is one bit wider so delay+width cannot wrap; a zero width
  // makes the window empty, and the cpp bound clips pulses at the point end.
  always_comb begin
    win_end = {1'b0, delay_q} + {1'b0, width_q};
    active  = en_q && (cyc >= delay_q) && ({1'b0, cyc} < win_end) && (cyc < cpp);
  end

  // Outside an active step the output rests at the live inactive level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      trig <= 1'b0;
    end else if (run) begin
      trig <= active ^ pol_q;
    end else begin
      trig <= pol_in;
    end
  end

endmodule

// File: rtl/scan_trigger_gen.sv
// ---------------------------------------------------------------------------
// scan_trigger_gen
// N-channel raster scan timing generator. On an accepted start it walks
// cfg_lines x cfg_points points of cfg_cpp clocks each, with every channel
// emitting a programmable pulse per point. One-shot or continuous.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   bus (slave)        : start/abort, cfg_* inputs; busy, trig_out,
//                        line_start, point_idx, line_idx, done, cfg_err
// ---------------------------------------------------------------------------
module scan_trigger_gen
  import scan_timing_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  scan_trigger_gen_if.slave bus
);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  points_q;
  logic [CNT_W-1:0]  lines_q;
  logic [CNT_W-1:0]  cpp_q;
  logic              repeat_q;
  logic [CNT_W-1:0]  cyc_q;
  logic [CNT_W-1:0]  pt_q;
  logic [CNT_W-1:0]  ln_q;
  logic              cfg_ok;
  logic              load;
  logic              run;
  logic              done_set;
  logic              err_set;
  logic              cyc_wrap;
  logic              pt_wrap;
  logic              ln_wrap;
  logic              last_cyc;
  logic              line_start_q;
  logic [CNT_W-1:0]  point_idx_q;
  logic [CNT_W-1:0]  line_idx_q;
  logic              done_q;
  logic              err_q;
  logic [NUM_CH-1:0] trig_vec;

  // A start is only usable if every dimension is non-zero and each enabled
  // channel begins inside the point.
  always_comb begin
    cfg_ok = (bus.cfg_cpp != '0) && (bus.cfg_points != '0) && (bus.cfg_lines != '0);
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.cfg_ch_en[i] && (bus.cfg_ch_delay[i*CNT_W +: CNT_W] >= bus.cfg_cpp)) begin
        cfg_ok = 1'b0;
      end
    end
  end

  always_comb begin
    cyc_wrap = (cyc_q == cpp_q - 1'b1);
    pt_wrap  = (pt_q == points_q - 1'b1);
    ln_wrap  = (ln_q == lines_q - 1'b1);
    last_cyc = cyc_wrap && pt_wrap && ln_wrap;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort takes priority over frame completion so only one done is raised.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    run      = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            load    = 1'b1;
            state_d = ST_RUN;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          run = 1'b1;
          if (last_cyc && !repeat_q) begin
            done_set = 1'b1;
            state_d  = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      points_q <= '0;
      lines_q  <= '0;
      cpp_q    <= '0;
      repeat_q <= 1'b0;
    end else if (load) begin
      points_q <= bus.cfg_points;
      lines_q  <= bus.cfg_lines;
      cpp_q    <= bus.cfg_cpp;
      repeat_q <= bus.cfg_repeat;
    end
  end

  // Raster counters; the final wrap of a one-shot frame leaves them at zero.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cyc_q <= '0;
      pt_q  <= '0;
      ln_q  <= '0;
    end else if (run) begin
      if (cyc_wrap) begin
        cyc_q <= '0;
        if (pt_wrap) begin
          pt_q <= '0;
          ln_q <= ln_wrap ? '0 : ln_q + 1'b1;
        end else begin
          pt_q <= pt_q + 1'b1;
        end
      end else begin
        cyc_q <= cyc_q + 1'b1;
      end
    end else begin
      cyc_q <= '0;
      pt_q  <= '0;
      ln_q  <= '0;
    end
  end

  // Status outputs share the one-clock latency of the channel registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      line_start_q <= 1'b0;
      point_idx_q  <= '0;
      line_idx_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      line_start_q <= run && (cyc_q == '0) && (pt_q == '0);
      point_idx_q  <= run ? pt_q : '0;
      line_idx_q   <= run ? ln_q : '0;
      done_q       <= done_set;
      err_q        <= err_set;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    scan_trig_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .load     (load),
      .run      (run),
      .delay_in (bus.cfg_ch_delay[g*CNT_W +: CNT_W]),
      .width_in (bus.cfg_ch_width[g*CNT_W +: CNT_W]),
      .en_in    (bus.cfg_ch_en[g]),
      .pol_in   (bus.cfg_ch_pol[g]),
      .cyc      (cyc_q),
      .cpp      (cpp_q),
      .trig     (trig_vec[g])
    );
  end

  assign bus.busy       = (state_q == ST_RUN);
  assign bus.trig_out   = trig_vec;
  assign bus.line_start = line_start_q;
  assign bus.point_idx  = point_idx_q;
  assign bus.line_idx   = line_idx_q;
  assign bus.done       = done_q;
  assign bus.cfg_err    = err_q;

endmodule

// File: tb/tb_scan_trigger_gen.sv
// ---------------------------------------------------------------------------
// tb_scan_trigger_gen
// Testbench for scan_trigger_gen (NUM_CH=2, CNT_W=16). Expected per-cycle
// outputs are computed from the raster formula when a start is driven and
// queued; each test pops and compares them as the DUT runs.
// ---------------------------------------------------------------------------
module tb_scan_trigger_gen;

  typedef struct packed {
    logic [1:0]  trig;
    logic        line_start;
    logic [15:0] pidx;
    logic [15:0] lidx;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  exp_t exp_q[$];

  always #5 sys_clk = ~sys_clk;

  scan_trigger_gen_if #(.NUM_CH(2), .CNT_W(16)) bus ();

  scan_trigger_gen #(.NUM_CH(2), .CNT_W(16)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  // Sample the DUT outputs into the same shape as an expectation.
  function automatic exp_t observe();
    exp_t o;
    o.trig       = bus.trig_out;
    o.line_start = bus.line_start;
    o.pidx       = bus.point_idx;
    o.lidx       = bus.line_idx;
    o.busy       = bus.busy;
    o.done       = bus.done;
    o.err        = bus.cfg_err;
    return o;
  endfunction

  function automatic string fmt(exp_t v);
    return $sformatf("trig=%b ls=%b pt=%0d ln=%0d busy=%b done=%b err=%b",
                     v.trig, v.line_start, v.pidx, v.lidx, v.busy, v.done, v.err);
  endfunction

  task automatic set_cfg(input int cpp, input int pts, input int lns,
                         input int d0, input int w0, input int d1, input int w1,
                         input logic [1:0] en, input logic [1:0] pol, input logic rpt);
    bus.cfg_cpp      = 16'(cpp);
    bus.cfg_points   = 16'(pts);
    bus.cfg_lines    = 16'(lns);
    bus.cfg_ch_delay = {16'(d1), 16'(d0)};
    bus.cfg_ch_width = {16'(w1), 16'(w0)};
    bus.cfg_ch_en    = en;
    bus.cfg_ch_pol   = pol;
    bus.cfg_repeat   = rpt;
  endtask

  // Queue the expected output for each sample k after the start edge
  // (k=1 is the first RUN cycle, still showing idle levels). With
  // abort_k>0 the frame repeats and the abort is seen at edge k=abort_k.
  task automatic push_stream(input int cpp, input int pts, input int lns,
                             input int d0, input int w0, input int d1, input int w1,
                             input logic [1:0] en, input logic [1:0] pol, input int abort_k);
    int   total;
    int   last_k;
    int   n;
    int   c;
    int   p;
    int   l;
    int   lim;
    int   dd[2];
    int   ww[2];
    exp_t e;
    dd[0]  = d0;
    dd[1]  = d1;
    ww[0]  = w0;
    ww[1]  = w1;
    total  = cpp * pts * lns;
    last_k = (abort_k > 0) ? abort_k + 2 : total + 2;
    for (int k = 1; k <= last_k; k++) begin
      e      = '0;
      e.trig = pol;
      if (abort_k > 0 && k == abort_k + 1) begin
        e.done = 1'b1;
      end else if (abort_k > 0 && k == abort_k + 2) begin
        e.done = 1'b0;
      end else if (k == 1) begin
        e.busy = 1'b1;
      end else if (abort_k == 0 && k == total + 2) begin
        e.done = 1'b0;
      end else begin
        n = k - 2;
        c = n % cpp;
        p = (n / cpp) % pts;
        l = (n / (cpp * pts)) % lns;
        for (int i = 0; i < 2; i++) begin
          lim       = (dd[i] + ww[i] < cpp) ? dd[i] + ww[i] : cpp;
          e.trig[i] = (en[i] && c >= dd[i] && c < lim) ^ pol[i];
        end
        e.line_start = (c == 0 && p == 0);
        e.pidx       = 16'(p);
        e.lidx       = 16'(l);
        e.busy       = (abort_k > 0) || (k <= total);
        e.done       = (abort_k == 0) && (k == total + 1);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(10, 3, 2, 2, 3, 0, 1, 2'b11, 2'b01, 1'b0);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (bus.trig_out !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_trig got=%b expected=00", bus.trig_out);
    end
    checks++;
    if ({bus.busy, bus.done, bus.cfg_err, bus.line_start} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags got busy/done/err/ls=%b expected=0000",
               {bus.busy, bus.done, bus.cfg_err, bus.line_start});
    end
    checks++;
    if ({bus.point_idx, bus.line_idx} !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_idx got pt=%0d ln=%0d expected 0 0", bus.point_idx, bus.line_idx);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (bus.trig_out !== 2'b01) begin
      errors++;
      $display("[TB] FAIL idle_pol got=%b expected=01", bus.trig_out);
    end
    bus.cfg_ch_pol = 2'b10;
    @(negedge sys_clk);
    checks++;
    if (bus.trig_out !== 2'b10) begin
      errors++;
      $display("[TB] FAIL idle_pol_follow got=%b expected=10", bus.trig_out);
    end
  endtask

  task automatic test_one_shot();
    exp_t e;
    exp_t o;
    logic [1:0] prev;
    int rise0;
    int rise1;
    int k;
    prev  = 2'b00;
    rise0 = 0;
    rise1 = 0;
    k     = 0;
    @(negedge sys_clk);
    set_cfg(10, 3, 2, 2, 3, 0, 1, 2'b11, 2'b00, 1'b0);
    bus.start = 1'b1;
    push_stream(10, 3, 2, 2, 3, 0, 1, 2'b11, 2'b00, 0);
    while (exp_q.size() > 0) begin
      @(negedge sys_clk);
      k++;
      bus.start = 1'b0;
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL one_shot k=%0d got %s expected %s", k, fmt(o), fmt(e));
      end
      if (o.trig[0] && !prev[0]) rise0++;
      if (o.trig[1] && !prev[1]) rise1++;
      prev = o.trig;
    end
    checks++;
    if (rise0 !== 6) begin
      errors++;
      $display("[TB] FAIL one_shot_ch0_pulses got=%0d expected=6", rise0);
    end
    checks++;
    if (rise1 !== 6) begin
      errors++;
      $display("[TB] FAIL one_shot_ch1_pulses got=%0d expected=6", rise1);
    end
  endtask

  task automatic test_cfg_err();
    for (int t = 0; t < 2; t++) begin
      @(negedge sys_clk);
      if (t == 0) set_cfg(0, 3, 2, 2, 3, 0, 1, 2'b11, 2'b00, 1'b0);
      else        set_cfg(10, 3, 2, 10, 3, 0, 1, 2'b01, 2'b00, 1'b0);
      bus.start = 1'b1;
      bus.abort = (t == 1);
      @(negedge sys_clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      checks++;
      if ({bus.cfg_err, bus.busy, bus.done} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL cfg_err_pulse t=%0d got err/busy/done=%b expected=100", t,
                 {bus.cfg_err, bus.busy, bus.done});
      end
      checks++;
      if (bus.trig_out !== 2'b00) begin
        errors++;
        $display("[TB] FAIL cfg_err_trig t=%0d got=%b expected=00", t, bus.trig_out);
      end
      @(negedge sys_clk);
      checks++;
      if ({bus.cfg_err, bus.busy} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL cfg_err_after t=%0d got err/busy=%b expected=00", t,
                 {bus.cfg_err, bus.busy});
      end
    end
  endtask

  task automatic test_clip();
    exp_t e;
    exp_t o;
    int lows;
    int k;
    lows = 0;
    k    = 0;
    @(negedge sys_clk);
    set_cfg(10, 1, 2, 8, 5, 0, 0, 2'b01, 2'b01, 1'b0);
    bus.start = 1'b1;
    push_stream(10, 1, 2, 8, 5, 0, 0, 2'b01, 2'b01, 0);
    while (exp_q.size() > 0) begin
      @(negedge sys_clk);
      k++;
      bus.start = 1'b0;
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL clip k=%0d got %s expected %s", k, fmt(o), fmt(e));
      end
      if (o.trig[0] === 1'b0) lows++;
    end
    checks++;
    if (lows !== 4) begin
      errors++;
      $display("[TB] FAIL clip_low_cycles got=%0d expected=4", lows);
    end
  endtask

  // Continuous run aborted mid-frame, then a one-shot aborted on its
  // very last RUN cycle where abort must swallow the frame-end done.
  task automatic test_abort();
    exp_t e;
    exp_t o;
    int k;
    int ak;
    for (int t = 0; t < 2; t++) begin
      k = 0;
      @(negedge sys_clk);
      if (t == 0) begin
        ak = 37;
        set_cfg(4, 2, 2, 1, 2, 0, 1, 2'b11, 2'b00, 1'b1);
        push_stream(4, 2, 2, 1, 2, 0, 1, 2'b11, 2'b00, ak);
      end else begin
        ak = 8;
        set_cfg(4, 1, 2, 0, 4, 3, 1, 2'b11, 2'b00, 1'b0);
        push_stream(4, 1, 2, 0, 4, 3, 1, 2'b11, 2'b00, ak);
      end
      bus.start = 1'b1;
      while (exp_q.size() > 0) begin
        @(negedge sys_clk);
        k++;
        bus.start = 1'b0;
        e = exp_q.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL abort t=%0d k=%0d got %s expected %s", t, k, fmt(o), fmt(e));
        end
        bus.abort = (k == ak);
      end
      bus.abort = 1'b0;
    end
  endtask

  // Abort in IDLE, then start pulses during RUN and FIN with the
  // configuration rewritten mid-frame; the running frame must not notice.
  task automatic test_ignore();
    exp_t e;
    exp_t o;
    int k;
    k = 0;
    @(negedge sys_clk);
    bus.abort = 1'b1;
    @(negedge sys_clk);
    bus.abort = 1'b0;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL idle_abort got busy/done=%b expected=00", {bus.busy, bus.done});
    end
    set_cfg(5, 2, 2, 1, 2, 3, 5, 2'b11, 2'b00, 1'b0);
    bus.start = 1'b1;
    push_stream(5, 2, 2, 1, 2, 3, 5, 2'b11, 2'b00, 0);
    exp_q[exp_q.size()-1].trig = 2'b11;
    while (exp_q.size() > 0) begin
      @(negedge sys_clk);
      k++;
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL ignore_start k=%0d got %s expected %s", k, fmt(o), fmt(e));
      end
      bus.start = (k == 4) || (k == 21);
      if (k == 4) set_cfg(7, 1, 2, 0, 6, 0, 0, 2'b10, 2'b11, 1'b0);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    exp_t o;
    int k;
    k = 0;
    @(negedge sys_clk);
    set_cfg(10, 3, 2, 2, 3, 0, 1, 2'b11, 2'b10, 1'b0);
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    repeat (14) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.trig_out, bus.busy, bus.line_start} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_run got trig=%b busy=%b ls=%b expected 00 0 0",
               bus.trig_out, bus.busy, bus.line_start);
    end
    checks++;
    if ({bus.point_idx, bus.line_idx} !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run_idx got pt=%0d ln=%0d expected 0 0", bus.point_idx, bus.line_idx);
    end
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    @(negedge sys_clk);
    checks++;
    if ({bus.trig_out, bus.busy} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_release got trig=%b busy=%b expected 10 0", bus.trig_out, bus.busy);
    end
    set_cfg(3, 2, 1, 1, 1, 0, 2, 2'b11, 2'b00, 1'b0);
    bus.start = 1'b1;
    push_stream(3, 2, 1, 1, 1, 0, 2, 2'b11, 2'b00, 0);
    while (exp_q.size() > 0) begin
      @(negedge sys_clk);
      k++;
      bus.start = 1'b0;
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL after_reset_run k=%0d got %s expected %s", k, fmt(o), fmt(e));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_one_shot();
    test_cfg_err();
    test_clip();
    test_abort();
    test_ignore();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
